cmsdk_ahb_burst_master: RTL and testbench

//  AHB-Lite initiator that turns one command into one complete burst: NONSEQ/SEQ/BUSY/IDLE

---
 rtl/cmsdk_ahb_burst_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cmsdk_ahb_burst_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_ahb_burst_master.sv
// -----------------------------------------------------------------------------
// cmsdk_ahb_burst_master
//
// AHB-Lite initiator that turns one command into one complete burst.
// It sequences NONSEQ/SEQ (and optionally BUSY) transfers, drives HBURST and
// HMASTLOCK, absorbs HREADY wait states, and handles the two-cycle ERROR
// response by cancelling the rest of the burst. Only word transfers are issued.
//
// Optional feature macro: AHB_BURST_MASTER_BUSY_EN
//   Defined   : bursts of 3 or more beats insert one BUSY cycle after the 2nd
//               beat's address is accepted.
//   Undefined : no BUSY transfers; SEQ beats are issued back-to-back.
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only when idle)
//   cmd_write           1 = write burst, 0 = read burst
//   cmd_addr            start address (bits [1:0] ignored)
//   cmd_burst           HBURST encoding for the burst
//   cmd_len             INCR beat count (0 -> 1, >16 -> 16)
//   cmd_lock            hold HMASTLOCK for the burst
//   cmd_wbase           write data seed; beat n carries cmd_wbase + n
//   HADDR..HWDATA       AHB-Lite master outputs
//   HREADY/HRESP/HRDATA AHB-Lite slave responses
//   rd_valid/rd_data    one pulse per OKAY read beat, registered data
//   done/err            end-of-burst pulse; err marks an ERROR cancel
// -----------------------------------------------------------------------------
module cmsdk_ahb_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [4:0]            cmd_len,
    input  logic                  cmd_lock,
    input  logic [DATA_WIDTH-1:0] cmd_wbase,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic                  HWRITE,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST, ST_ERR} state_t;
    typedef enum logic [1:0] {
        TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11
    } htrans_t;
    typedef enum logic [2:0] {
        HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16
    } hburst_t;

    function automatic logic [4:0] beat_count(input hburst_t burst, input logic [4:0] len);
        case (burst)
            HB_SINGLE:          return 5'd1;
            HB_INCR: begin
                if (len == 5'd0)  return 5'd1;
                if (len > 5'd16)  return 5'd16;
                return len;
            end
            HB_WRAP4, HB_INCR4: return 5'd4;
            HB_WRAP8, HB_INCR8: return 5'd8;
            default:            return 5'd16;
        endcase
    endfunction

    // +4 step; wrapping bursts keep the upper bits of their aligned window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input hburst_t burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        case (burst)
            HB_WRAP4:  mask = ADDR_WIDTH'(32'h0F);
            HB_WRAP8:  mask = ADDR_WIDTH'(32'h1F);
            HB_WRAP16: mask = ADDR_WIDTH'(32'h3F);
            default:   mask = '1;
        endcase
        inc = addr + ADDR_WIDTH'(4);
        return (addr & ~mask) | (inc & mask);
    endfunction

    // An incrementing step landing on a 1KB boundary must restart as NONSEQ.
    function automatic htrans_t seq_type(input logic [9:0] addr_lo, input hburst_t burst);
        if ((burst == HB_INCR || burst == HB_INCR4 || burst == HB_INCR8 ||
             burst == HB_INCR16) && addr_lo == 10'd0)
            return TR_NONSEQ;
        return TR_SEQ;
    endfunction

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] haddr_q,   haddr_d;
    htrans_t               htrans_q,  htrans_d;
    hburst_t               hburst_q,  hburst_d;
    logic                  hwrite_q,  hwrite_d;
    logic                  hlock_q,   hlock_d;
    logic [DATA_WIDTH-1:0] hwdata_q,  hwdata_d;
    logic [DATA_WIDTH-1:0] wbase_q,   wbase_d;
    logic [4:0]            beat_q,    beat_d;     // beats whose address was accepted
    logic [4:0]            total_q,   total_d;
    logic                  dphase_q,  dphase_d;   // a NONSEQ/SEQ data phase is in flight
    logic                  dwrite_q,  dwrite_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  done_q,    done_d;
    logic                  err_q,     err_d;

    logic                  addr_ok;
    logic                  err_first;
    logic [ADDR_WIDTH-1:0] step_addr;

    assign addr_ok   = HREADY && (htrans_q == TR_NONSEQ || htrans_q == TR_SEQ);
    // First ERROR cycle: the pending address phase is not accepted, so it may be
    // withdrawn to IDLE on the next cycle.
    assign err_first = dphase_q && HRESP && !HREADY;
    assign step_addr = next_addr(haddr_q, hburst_q);

    always_comb begin
        // NOTE: every signal is given a default before any branch so that no
        // path through this block can infer a latch.
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hburst_d   = hburst_q;
        hwrite_d   = hwrite_q;
        hlock_d    = hlock_q;
        hwdata_d   = hwdata_q;
        wbase_d    = wbase_q;
        beat_d     = beat_q;
        total_d    = total_q;
        dphase_d   = dphase_q;
        dwrite_d   = dwrite_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (HREADY) begin
            dphase_d = addr_ok;
            dwrite_d = hwrite_q;
        end

        if (dphase_q && !dwrite_q && HREADY && !HRESP) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_ADDR;
                    haddr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                    htrans_d = TR_NONSEQ;
                    hburst_d = hburst_t'(cmd_burst);
                    hwrite_d = cmd_write;
                    hlock_d  = cmd_lock;
                    wbase_d  = cmd_wbase;
                    beat_d   = 5'd0;
                    total_d  = beat_count(hburst_t'(cmd_burst), cmd_len);
                end
            end
            ST_ADDR: begin
                if (err_first) begin
                    htrans_d = TR_IDLE;
                    hlock_d  = 1'b0;
                    state_d  = ST_ERR;
                end else if (addr_ok) begin
                    beat_d = beat_q + 5'd1;
                    if (hwrite_q) hwdata_d = wbase_q + DATA_WIDTH'(beat_q);
                    if (beat_q + 5'd1 == total_q) begin
                        htrans_d = TR_IDLE;
                        hlock_d  = 1'b0;
                        state_d  = ST_LAST;
                    end else begin
                        haddr_d = step_addr;
`ifdef AHB_BURST_MASTER_BUSY_EN
                        // HADDR already moves to beat 3 while BUSY is shown.
                        if (beat_q == 5'd1 && total_q >= 5'd3) htrans_d = TR_BUSY;
                        else
`endif
                        htrans_d = seq_type(step_addr[9:0], hburst_q);
                    end
                end
`ifdef AHB_BURST_MASTER_BUSY_EN
                else if (HREADY && htrans_q == TR_BUSY) begin
                    htrans_d = seq_type(haddr_q[9:0], hburst_q);
                end
`endif
            end
            ST_LAST: begin
                if (err_first) begin
                    state_d = ST_ERR;
                end else if (HREADY) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin  // ST_ERR: wait for the second ERROR cycle
                if (HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TR_IDLE;
            hburst_q   <= HB_SINGLE;
            hwrite_q   <= 1'b0;
            hlock_q    <= 1'b0;
            hwdata_q   <= '0;
            wbase_q    <= '0;
            beat_q     <= '0;
            total_q    <= '0;
            dphase_q   <= 1'b0;
            dwrite_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hburst_q   <= hburst_d;
            hwrite_q   <= hwrite_d;
            hlock_q    <= hlock_d;
            hwdata_q   <= hwdata_d;
            wbase_q    <= wbase_d;
            beat_q     <= beat_d;
            total_q    <= total_d;
            dphase_q   <= dphase_d;
            dwrite_q   <= dwrite_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HBURST    = hburst_q;
    assign HSIZE     = 3'b010;
    assign HWRITE    = hwrite_q;
    assign HMASTLOCK = hlock_q;
    assign HWDATA    = hwdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cmsdk_ahb_burst_master.sv
// -----------------------------------------------------------------------------
// tb_cmsdk_ahb_burst_master
//
// Bench for cmsdk_ahb_burst_master. The bench plays the AHB slave, records
// every accepted address phase, write data beat and read pulse, and compares
// them with the transfer list derived from the burst rules (beat count, +4
// stepping, wrap windows, 1KB restarts, BUSY insertion, ERROR truncation).
// -----------------------------------------------------------------------------
module tb_cmsdk_ahb_burst_master;

`ifdef AHB_BURST_MASTER_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_lock;
    logic [31:0] cmd_addr, cmd_wbase;
    logic [2:0]  cmd_burst;
    logic [4:0]  cmd_len;
    logic [31:0] HADDR, HWDATA, HRDATA, rd_data;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP, rd_valid, done, err;

    int checks = 0;
    int errors = 0;

    cmsdk_ahb_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .cmd_lock(cmd_lock), .cmd_wbase(cmd_wbase),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] burst, input logic [4:0] len);
        case (burst)
            3'd0:       return 1;
            3'd1:       return (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    // One complete burst: model, command, slave/monitor loop, comparisons.
    task automatic do_burst(input string name, input bit wr, input logic [31:0] addr,
                            input logic [2:0] burst, input logic [4:0] len, input bit lock,
                            input logic [31:0] wbase, input int stall_beat,
                            input int stall_cycles, input int stall_pct, input int err_beat);
        int unsigned start, base, size, a;
        int          beats, ok_beats, cyc, last_comp, done_cyc, nacc, dph_beat;
        int          stall_left, err_st, unstable, lock_idle_bad, ctrl_bad, err2_bad, n_cmp;
        bit          dph, dph_wr, stalled_once, done_seen, err_seen, prev_low, rdy, rsp;
        logic [31:0] p_addr, p_wdata, rdata;
        logic [1:0]  p_trans;
        logic [31:0] ea[$], o_addr[$], o_wd[$], o_rd[$], x_rd[$];
        logic [1:0]  et[$], o_trans[$];

        // Reference transfer list from the burst rules.
        beats    = beats_of(burst, len);
        ok_beats = (err_beat >= 0) ? err_beat : beats;
        start    = addr & ~32'h3;
        for (int n = 0; n < beats; n++) begin
            if (err_beat >= 0 && n > err_beat) break;
            if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
                size = beats * 4;
                base = start - (start % size);
                a    = base + ((start - base + 4 * n) % size);
            end else begin
                a = start + 4 * n;
            end
            if (BUSY_EN && beats >= 3 && n == 2) begin
                ea.push_back(a);
                et.push_back(2'b01);
            end
            ea.push_back(a);
            if (n == 0 || (burst[0] && (a % 1024) == 0)) et.push_back(2'b10);
            else                                         et.push_back(2'b11);
        end

        check({name, " ready"}, cmd_ready, 1'b1);
        cmd_write = wr; cmd_addr = addr; cmd_burst = burst; cmd_len = len;
        cmd_lock = lock; cmd_wbase = wbase; cmd_valid = 1'b1;
        HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;

        dph = 0; dph_wr = 0; dph_beat = 0; nacc = 0; stall_left = 0; err_st = 0;
        stalled_once = 0; done_seen = 0; err_seen = 0; prev_low = 0;
        unstable = 0; lock_idle_bad = 0; ctrl_bad = 0; err2_bad = 0;
        last_comp = -10; done_cyc = -1;
        p_addr = '0; p_wdata = '0; p_trans = '0;

        for (cyc = 0; cyc < 400; cyc++) begin
            if (rd_valid) o_rd.push_back(rd_data);
            if (done) begin
                done_seen = 1; err_seen = err; done_cyc = cyc;
                break;
            end
            if (prev_low && (HADDR !== p_addr || HTRANS !== p_trans || HWDATA !== p_wdata))
                unstable++;
            if (HTRANS == 2'b00 && HMASTLOCK) lock_idle_bad++;

            rdy = 1; rsp = 0; rdata = $urandom;
            if (dph) begin
                if (err_st == 1) begin
                    rsp = 1; err_st = 2;
                    if (HTRANS !== 2'b00 || HMASTLOCK !== 1'b0) err2_bad++;
                end else if (dph_beat == err_beat && err_st == 0) begin
                    rdy = 0; rsp = 1; err_st = 1;
                end else begin
                    if (dph_beat == stall_beat && !stalled_once) begin
                        stalled_once = 1; stall_left = stall_cycles;
                    end
                    if (stall_left > 0) begin
                        rdy = 0; stall_left--;
                    end else if (int'($urandom_range(99)) < stall_pct) begin
                        rdy = 0;
                    end
                end
            end

            prev_low = !rdy && !rsp;
            p_addr = HADDR; p_trans = HTRANS; p_wdata = HWDATA;
            if (rdy) begin
                if (dph) begin
                    last_comp = cyc;
                    if (!rsp) begin
                        if (dph_wr) o_wd.push_back(HWDATA);
                        else        x_rd.push_back(rdata);
                    end
                end
                if (HTRANS != 2'b00) begin
                    o_addr.push_back(HADDR);
                    o_trans.push_back(HTRANS);
                    if (HMASTLOCK !== lock || HWRITE !== wr || HBURST !== burst ||
                        HSIZE !== 3'b010) ctrl_bad++;
                end
                dph = (HTRANS == 2'b10 || HTRANS == 2'b11);
                if (dph) begin
                    dph_beat = nacc; nacc++; dph_wr = HWRITE;
                end
            end
            HREADY = rdy; HRESP = rsp; HRDATA = rdata;
            @(posedge HCLK); #1;
        end
        HREADY = 1'b1; HRESP = 1'b0;

        check({name, " done"}, done_seen, 1'b1);
        check({name, " err"}, err_seen, (err_beat >= 0));
        check({name, " done_latency"}, done_cyc, last_comp + 1);
        check({name, " n_addr"}, o_addr.size(), ea.size());
        n_cmp = (o_addr.size() < ea.size()) ? o_addr.size() : ea.size();
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("%s haddr%0d", name, i), o_addr[i], ea[i]);
            check($sformatf("%s htrans%0d", name, i), o_trans[i], et[i]);
        end
        if (wr) begin
            check({name, " n_wdata"}, o_wd.size(), ok_beats);
            for (int i = 0; i < o_wd.size() && i < ok_beats; i++)
                check($sformatf("%s hwdata%0d", name, i), o_wd[i], wbase + 32'(i));
            check({name, " no_rd_valid"}, o_rd.size(), 0);
        end else begin
            check({name, " n_rd"}, o_rd.size(), ok_beats);
            for (int i = 0; i < o_rd.size() && i < x_rd.size(); i++)
                check($sformatf("%s rd_data%0d", name, i), o_rd[i], x_rd[i]);
        end
        check({name, " stable_in_wait"}, unstable, 0);
        check({name, " lock_dropped_on_idle"}, lock_idle_bad, 0);
        check({name, " ctrl"}, ctrl_bad, 0);
        if (err_beat >= 0) begin
            check({name, " err_second_cycle_reached"}, err_st, 2);
            check({name, " idle_unlocked_on_err2"}, err2_bad, 0);
        end

        if (!done_seen) begin
            HRESET = 1'b1; #2; HRESET = 1'b0;
        end else begin
            @(posedge HCLK); #1;
            check({name, " done_one_cycle"}, done, 1'b0);
            check({name, " ready_after"}, cmd_ready, 1'b1);
            check({name, " idle_after"}, HTRANS, 2'b00);
        end
    endtask

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_burst = '0; cmd_len = '0; cmd_lock = 1'b0; cmd_wbase = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst htrans", HTRANS, 2'b00);
        check("rst haddr", HADDR, 32'h0);
        check("rst hburst", HBURST, 3'b000);
        check("rst hwrite", HWRITE, 1'b0);
        check("rst hmastlock", HMASTLOCK, 1'b0);
        check("rst hwdata", HWDATA, 32'h0);
        check("rst cmd_ready", cmd_ready, 1'b1);
        check("rst rd_valid", rd_valid, 1'b0);
        check("rst done_err", {done, err}, 2'b00);
        check("rst rd_data", rd_data, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        check("post_rst idle", HTRANS, 2'b00);

        do_burst("t1_incr4_wr", 1, 32'h100, 3'd3, 5'd0, 0, 32'hA0, -1, 0, 0, -1);
        do_burst("t2_wrap8_rd", 0, 32'h38, 3'd4, 5'd0, 0, 32'h0, -1, 0, 0, -1);
        do_burst("t3_incr3_1kb", 0, 32'h3F8, 3'd1, 5'd3, 0, 32'h0, -1, 0, 0, -1);
        do_burst("t4_incr8_stall", 1, 32'h200, 3'd5, 5'd0, 0, 32'h5000, 1, 3, 0, -1);
        do_burst("t5_incr16_err", 0, 32'h1000, 3'd7, 5'd0, 1, 32'h0, -1, 0, 0, 4);
        do_burst("t_len0", 1, 32'h44, 3'd1, 5'd0, 0, 32'h77, -1, 0, 0, -1);
        do_burst("t_len_sat", 1, 32'h80, 3'd1, 5'd25, 1, 32'h10, -1, 0, 0, -1);
        do_burst("t_wrap16_wr", 1, 32'h7F4, 3'd6, 5'd0, 1, 32'hC0, -1, 0, 30, -1);
        do_burst("t_single_err", 1, 32'h10, 3'd0, 5'd0, 0, 32'h1, -1, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            logic [2:0]  b;
            logic [4:0]  ln;
            logic [31:0] ad;
            int          bl, eb;
            b  = 3'($urandom_range(7));
            ln = 5'($urandom_range(31));
            bl = beats_of(b, ln);
            ad = 32'(($urandom_range(1, 15) << 10) - ($urandom_range(0, 10) << 2)
                     + $urandom_range(0, 3));
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(0, bl - 1)) : -1;
            do_burst($sformatf("rnd%0d", i), 1'($urandom_range(1)), ad, b, ln,
                     1'($urandom_range(1)), $urandom, -1, 0, 25, eb);
        end

        // Asynchronous reset in the middle of a locked burst.
        cmd_write = 1'b0; cmd_addr = 32'h300; cmd_burst = 3'd5; cmd_len = '0;
        cmd_lock = 1'b1; cmd_valid = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge HCLK);
        #3;
        check("t6 busy_mid_burst", (HTRANS != 2'b00), 1'b1);
        check("t6 locked_mid_burst", HMASTLOCK, 1'b1);
        HRESET = 1'b1;
        #1;
        check("t6 rst htrans", HTRANS, 2'b00);
        check("t6 rst cmd_ready", cmd_ready, 1'b1);
        check("t6 rst haddr", HADDR, 32'h0);
        check("t6 rst hmastlock", HMASTLOCK, 1'b0);
        check("t6 rst hburst", HBURST, 3'b000);
        check("t6 rst done", done, 1'b0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        check("t6 no_done_after_rst", done, 1'b0);
        do_burst("t6_recover", 1, 32'h20, 3'd3, 5'd0, 0, 32'h900, -1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
